spm_responder: RTL



---
 rtl/spm_responder_pkg.sv | 18 +
 rtl/spm_resp_pipe.sv | 41 ++++
 rtl/spm_responder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/spm_responder_pkg.sv
// Shared types and constants for the SPM responder scratchpad.
// Optional stall injection is enabled with SPM_RESPONDER_STALL_EN.
package spm_responder_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int byte_off_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/spm_resp_pipe.sv
// Fixed-latency read response pipeline: valid+data shift register, async clear,
// data forced to zero whenever the output is not valid.
module spm_resp_pipe #(
    parameter int Latency   = 2,
    parameter int DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o
);

    logic [Latency-1:0]   valid_q;
    logic [DataWidth-1:0] data_q [Latency];

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's pre-edge value; blocking here would collapse the pipe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < Latency; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign rvalid_o = valid_q[Latency-1];
    assign rdata_o  = valid_q[Latency-1] ? data_q[Latency-1] : '0;

endmodule

// File: rtl/spm_responder.sv
// SPM bus responder: register-array scratchpad, cleared after every reset, with
// fixed read latency. Define SPM_RESPONDER_STALL_EN for LFSR-driven ready stalls.
module spm_responder
    import spm_responder_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int NumWords  = 256,
    parameter int Latency   = 2,
    parameter int StrbWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [StrbWidth-1:0] strb_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 init_done_o
);

    localparam int OffW = byte_off_width(DataWidth);
    localparam int IdxW = $clog2(NumWords);

    state_e               state_q, state_d;
    logic [IdxW-1:0]      cnt_q, cnt_d;
    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 serve;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [IdxW-1:0]      idx;
    logic [DataWidth-1:0] wr_word;
    logic                 unused_addr_bits;

    // Only the word-index field of the byte address selects a word.
    assign idx              = addr_i[OffW +: IdxW];
    assign unused_addr_bits = ^addr_i;

    assign serve       = (state_q == SERVE);
    assign init_done_o = serve;
    assign wr_acc      = valid_i && ready_o && we_i;
    assign rd_acc      = valid_i && ready_o && !we_i;

`ifdef SPM_RESPONDER_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (serve) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ready_o = serve && (lfsr_q[1:0] != 2'b00);
`else
    assign ready_o = serve;
`endif

    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IdxW'(NumWords - 1)) begin
                    state_d = SERVE;
                end
            end
            SERVE:   state_d = SERVE;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        wr_word = mem_q[idx];
        for (int b = 0; b < StrbWidth; b++) begin
            if (strb_i[b]) begin
                wr_word[8*b +: 8] = wdata_i[8*b +: 8];
            end
        end
    end

    // NOTE: the array deliberately has no reset; the INIT sweep zeroes it one word
    // per cycle, which keeps it mappable to plain storage without a reset tree.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[idx] <= wr_word;
        end
    end

    spm_resp_pipe #(
        .Latency   (Latency),
        .DataWidth (DataWidth)
    ) u_pipe (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (rd_acc),
        .data_i   (mem_q[idx]),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

endmodule
